// File: rtl/cpu5401_pkg.sv
// +----------------------------------------------------------------------+
// | cpu5401_pkg                                                          |
// | Shared widths and jump-FSM state type for the CPU5401 memory block.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package cpu5401_pkg;

  localparam int NIBBLE_W  = 4;
  localparam int ADDR_W    = 8;
  localparam int RAM_DEPTH = 16;
  localparam int RAM_AW    = $clog2(RAM_DEPTH);

  typedef enum logic [0:0] {
    J_IDLE = 1'b0,
    J_HI   = 1'b1
  } jump_state_t;

endpackage

`default_nettype wire

// File: rtl/cpu5401_mem_ctrl_if.sv
// +----------------------------------------------------------------------+
// | cpu5401_mem_ctrl_if                                                  |
// | CPU strobe/data bus and program-ROM port of the memory controller.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface cpu5401_mem_ctrl_if;
  import cpu5401_pkg::*;

  logic [NIBBLE_W-1:0] rr;
  logic                mar;
  logic                write;
  logic                jmp;
  logic                i;
  logic [NIBBLE_W-1:0] rom_d;
  logic [NIBBLE_W-1:0] d;
  logic [ADDR_W-1:0]   rom_addr;
  logic [NIBBLE_W-1:0] page;
  logic                jerr;

  modport master (
    output rr, mar, write, jmp, i, rom_d,
    input  d, rom_addr, page, jerr
  );

  modport slave (
    input  rr, mar, write, jmp, i, rom_d,
    output d, rom_addr, page, jerr
  );

endinterface

`default_nettype wire

// File: rtl/cpu5401_ram16x4.sv
// +----------------------------------------------------------------------+
// | cpu5401_ram16x4                                                      |
// | 16x4 flop RAM, one write port, one combinational read port.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module cpu5401_ram16x4
  import cpu5401_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [RAM_AW-1:0]   waddr,
  input  logic [NIBBLE_W-1:0] wdata,
  input  logic [RAM_AW-1:0]   raddr,
  output logic [NIBBLE_W-1:0] rdata
);

  logic [NIBBLE_W-1:0] r_mem [RAM_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RAM_DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/cpu5401_mem_ctrl.sv
// +----------------------------------------------------------------------+
// | cpu5401_mem_ctrl                                                     |
// | MAR shifter, RAM, program counter and two-nibble jump loader.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module cpu5401_mem_ctrl
  import cpu5401_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  cpu5401_mem_ctrl_if.slave   bus
);

  logic [ADDR_W-1:0]   r_mar;
  logic [ADDR_W-1:0]   w_mar_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic [NIBBLE_W-1:0] r_jhi;
  logic [NIBBLE_W-1:0] w_jhi_nxt;
  logic                r_jerr;
  logic                w_jerr_nxt;
  logic [NIBBLE_W-1:0] r_d;
  logic [NIBBLE_W-1:0] w_d_nxt;
  logic [NIBBLE_W-1:0] w_ram_rdata;
  logic                w_bypass;
  jump_state_t         r_state;
  jump_state_t         w_state_nxt;

  assign w_mar_nxt = bus.mar ? {r_mar[NIBBLE_W-1:0], bus.rr} : r_mar;

  // Write uses the pre-shift address; read looks at the post-shift address.
  cpu5401_ram16x4 u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bus.write),
    .waddr (r_mar[RAM_AW-1:0]),
    .wdata (bus.rr),
    .raddr (w_mar_nxt[RAM_AW-1:0]),
    .rdata (w_ram_rdata)
  );

  assign w_bypass = bus.write && (r_mar[RAM_AW-1:0] == w_mar_nxt[RAM_AW-1:0]);

  always_comb begin
    w_d_nxt = w_ram_rdata;
    if (bus.i) begin
      w_d_nxt = bus.rom_d;
    end else if (w_bypass) begin
      w_d_nxt = bus.rr;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_jhi_nxt   = r_jhi;
    w_jerr_nxt  = r_jerr;
    w_pc_nxt    = bus.i ? r_pc + 8'd1 : r_pc;
    case (r_state)
      J_IDLE: begin
        if (bus.jmp) begin
          w_jhi_nxt   = bus.rr;
          w_state_nxt = J_HI;
        end
      end
      J_HI: begin
        w_state_nxt = J_IDLE;
        if (bus.jmp) begin
          w_pc_nxt = {r_jhi, bus.rr};
        end else begin
          w_jerr_nxt = 1'b1;
        end
      end
      default: w_state_nxt = J_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= J_IDLE;
      r_mar   <= '0;
      r_pc    <= '0;
      r_jhi   <= '0;
      r_jerr  <= 1'b0;
      r_d     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mar   <= w_mar_nxt;
      r_pc    <= w_pc_nxt;
      r_jhi   <= w_jhi_nxt;
      r_jerr  <= w_jerr_nxt;
      r_d     <= w_d_nxt;
    end
  end

  assign bus.d        = r_d;
  assign bus.rom_addr = r_pc;
  assign bus.page     = r_mar[ADDR_W-1:NIBBLE_W];
  assign bus.jerr     = r_jerr;

endmodule

`default_nettype wire
